demux_1x4_reg: RTL and testbench

DEMUX_1X4_REG -- requirements
Module: demux_1x4_reg

---
 rtl/demux_1x4_reg.sv | 109 ++++++++++
 tb/tb_demux_1x4_reg.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1x4_reg.sv
// demux_1x4_reg: 1-to-4 registered demultiplexer with a per-channel valid/ack handshake.
// Define DEMUX_ERR_EN to add the sticky err output that flags dropped words.
module demux_1x4_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s1,
  input  logic         s0,
  input  logic [W-1:0] d,
  input  logic         vld,
  output logic         rdy,
  output logic [W-1:0] o0,
  output logic [W-1:0] o1,
  output logic [W-1:0] o2,
  output logic [W-1:0] o3,
  output logic         v0,
  output logic         v1,
  output logic         v2,
  output logic         v3,
  input  logic         ack0,
  input  logic         ack1,
  input  logic         ack2,
`ifdef DEMUX_ERR_EN
  output logic         err,
`endif
  input  logic         ack3
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_e;

  logic [1:0]          sel;
  logic [3:0]          ack_vec;
  logic [3:0]          full_vec;
  logic [3:0][W-1:0]   data_vec;
  logic                accept;

  assign sel     = {s1, s0};
  assign ack_vec = {ack3, ack2, ack1, ack0};

  // A FULL channel can still take a word when its consumer drains it in the same cycle.
  assign rdy    = !full_vec[sel] || ack_vec[sel];
  assign accept = vld && rdy;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      chan_state_e   state_q, state_d;
      logic [W-1:0]  data_q, data_d;
      logic          wr;

      assign wr = accept && (sel == 2'(gi));

      always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (wr) begin
          state_d = FULL;
          data_d  = d;
        end else if (ack_vec[gi] && (state_q == FULL)) begin
          state_d = EMPTY;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= EMPTY;
          data_q  <= '0;
        end else begin
          state_q <= state_d;
          data_q  <= data_d;
        end
      end

      assign full_vec[gi] = (state_q == FULL);
      assign data_vec[gi] = data_q;
    end
  endgenerate

  assign o0 = data_vec[0];
  assign o1 = data_vec[1];
  assign o2 = data_vec[2];
  assign o3 = data_vec[3];
  assign v0 = full_vec[0];
  assign v1 = full_vec[1];
  assign v2 = full_vec[2];
  assign v3 = full_vec[3];

`ifdef DEMUX_ERR_EN
  logic err_q, err_d;

  // Sticky: once a word has been dropped, only reset clears the flag.
  assign err_d = err_q || (vld && !rdy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_demux_1x4_reg.sv
// tb_demux_1x4_reg: randomized and directed checks of demux_1x4_reg against a
// channel-level reference model (per-channel occupancy and held word).
module tb_demux_1x4_reg;

  localparam int W = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   sel = '0;
  logic [W-1:0] d = '0;
  logic         vld = 1'b0;
  logic [3:0]   ack = '0;
  logic         rdy;
  logic [W-1:0] o0, o1, o2, o3;
  logic         v0, v1, v2, v3;
`ifdef DEMUX_ERR_EN
  logic         err;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: which channels hold a word, the word held, and the drop flag.
  logic         mv [4];
  logic [W-1:0] mo [4];
  logic         merr;

  always #5 clk = ~clk;

  demux_1x4_reg #(.W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .s1   (sel[1]),
    .s0   (sel[0]),
    .d    (d),
    .vld  (vld),
    .rdy  (rdy),
    .o0   (o0),
    .o1   (o1),
    .o2   (o2),
    .o3   (o3),
    .v0   (v0),
    .v1   (v1),
    .v2   (v2),
    .v3   (v3),
    .ack0 (ack[0]),
    .ack1 (ack[1]),
    .ack2 (ack[2]),
`ifdef DEMUX_ERR_EN
    .err  (err),
`endif
    .ack3 (ack[3])
  );

  function automatic logic [3:0] dut_v();
    return {v3, v2, v1, v0};
  endfunction

  function automatic logic [4*W-1:0] dut_o();
    return {o3, o2, o1, o0};
  endfunction

  function automatic logic [3:0] exp_v();
    return {mv[3], mv[2], mv[1], mv[0]};
  endfunction

  function automatic logic [4*W-1:0] exp_o();
    return {mo[3], mo[2], mo[1], mo[0]};
  endfunction

  // A channel takes a word if it is free now or is being drained this cycle.
  function automatic logic exp_rdy();
    return !mv[sel] || ack[sel];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0;
      mo[i] = '0;
    end
    merr = 1'b0;
  endtask

  task automatic model_edge();
    logic r;
    r = exp_rdy();
    for (int i = 0; i < 4; i++) begin
      if (vld && r && (sel == i[1:0])) begin
        mv[i] = 1'b1;
        mo[i] = d;
      end else if (ack[i]) begin
        mv[i] = 1'b0;
      end
    end
    if (vld && !r) merr = 1'b1;
  endtask

  task automatic drive(input logic [1:0] s, input logic [W-1:0] dd, input logic vl, input logic [3:0] a);
    sel = s;
    d   = dd;
    vld = vl;
    ack = a;
  endtask

  // Advance one clock; leaves time at posedge+1 so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic pulse_reset();
    drive(2'd0, '0, 1'b0, 4'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (dut_v() !== 4'b0) begin errors++; $display("FAIL reset_v got=%b exp=%b", dut_v(), 4'b0); end
    checks++;
    if (dut_o() !== '0) begin errors++; $display("FAIL reset_o got=%b exp=0", dut_o()); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%b exp=1", rdy); end
  endtask

  task automatic test_routing();
    for (int s = 0; s < 4; s++) begin
      pulse_reset();
      drive(s[1:0], 1'b1, 1'b1, 4'b0);
      tick();
      drive(s[1:0], 1'b0, 1'b0, 4'b0);
      checks++;
      if (dut_v() !== exp_v() || dut_v() !== (4'b1 << s))
        begin errors++; $display("FAIL routing_v sel=%0d got=%b exp=%b", s, dut_v(), exp_v()); end
      checks++;
      if (dut_o() !== exp_o())
        begin errors++; $display("FAIL routing_o sel=%0d got=%b exp=%b", s, dut_o(), exp_o()); end
      $display("routing sel=%0d v=%b o=%b", s, dut_v(), dut_o());
    end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    drive(2'd2, 1'b0, 1'b1, 4'b0);
    tick();
    drive(2'd2, 1'b1, 1'b1, 4'b0100);
    #1;
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy got=%b exp=1", rdy); end
    tick();
    drive(2'd0, 1'b0, 1'b0, 4'b0);
    checks++;
    if (v2 !== 1'b1 || o2 !== 1'b1 || dut_v() !== exp_v())
      begin errors++; $display("FAIL b2b_load v=%b o=%b exp_v=%b exp_o2=1", dut_v(), dut_o(), exp_v()); end
    $display("back_to_back v=%b o=%b", dut_v(), dut_o());
  endtask

  task automatic test_full_drop();
    pulse_reset();
    drive(2'd1, 1'b1, 1'b1, 4'b0);
    tick();
    drive(2'd1, 1'b0, 1'b1, 4'b0);
    #1;
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL drop_rdy got=%b exp=0", rdy); end
    tick();
    drive(2'd0, 1'b0, 1'b0, 4'b0);
    checks++;
    if (o1 !== 1'b1 || v1 !== 1'b1 || dut_v() !== exp_v())
      begin errors++; $display("FAIL drop_hold v=%b o=%b exp_v=%b", dut_v(), dut_o(), exp_v()); end
`ifdef DEMUX_ERR_EN
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL drop_err got=%b exp=1", err); end
    tick();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL drop_err_sticky got=%b exp=1", err); end
`endif
    $display("full_drop v=%b o=%b", dut_v(), dut_o());
  endtask

  task automatic test_independent_acks();
    pulse_reset();
    for (int s = 0; s < 4; s++) begin
      drive(s[1:0], W'($urandom), 1'b1, 4'b0);
      tick();
    end
    drive(2'd1, 1'b0, 1'b0, 4'b1001);
    tick();
    drive(2'd0, 1'b0, 1'b0, 4'b0);
    checks++;
    if (dut_v() !== 4'b0110 || dut_v() !== exp_v())
      begin errors++; $display("FAIL indep_acks_v got=%b exp=%b", dut_v(), exp_v()); end
    checks++;
    if (dut_o() !== exp_o())
      begin errors++; $display("FAIL indep_acks_o got=%b exp=%b", dut_o(), exp_o()); end
    $display("independent_acks v=%b o=%b", dut_v(), dut_o());
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    for (int s = 0; s < 4; s++) begin
      drive(s[1:0], 1'b1, 1'b1, 4'b0);
      tick();
    end
    drive(2'd2, 1'b1, 1'b1, 4'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_v() !== exp_v()) begin errors++; $display("FAIL rstmid_v got=%b exp=%b", dut_v(), exp_v()); end
    checks++;
    if (dut_o() !== exp_o()) begin errors++; $display("FAIL rstmid_o got=%b exp=%b", dut_o(), exp_o()); end
`ifdef DEMUX_ERR_EN
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL rstmid_err got=%b exp=0", err); end
`endif
    drive(2'd3, 1'b0, 1'b0, 4'b0);
    rst_n = 1'b1;
    #1;
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL rstmid_rdy got=%b exp=1", rdy); end
    $display("reset_mid v=%b o=%b rdy=%b", dut_v(), dut_o(), rdy);
  endtask

  task automatic test_sweep();
    for (int c = 0; c < 64; c++) begin
      logic [1:0] s;
      logic       dd, vl, st, ak;
      {s, dd, vl, st, ak} = 6'(c);
      pulse_reset();
      if (st) begin
        drive(s, ~dd, 1'b1, 4'b0);
        tick();
      end
      drive(s, dd, vl, 4'(ak) << s);
      #1;
      checks++;
      if (rdy !== exp_rdy())
        begin errors++; $display("FAIL sweep_rdy c=%0d got=%b exp=%b", c, rdy, exp_rdy()); end
      tick();
      drive(2'd0, 1'b0, 1'b0, 4'b0);
      checks++;
      if (dut_v() !== exp_v() || dut_o() !== exp_o())
        begin errors++; $display("FAIL sweep_state c=%0d v=%b o=%b exp_v=%b exp_o=%b", c, dut_v(), dut_o(), exp_v(), exp_o()); end
`ifdef DEMUX_ERR_EN
      checks++;
      if (err !== merr) begin errors++; $display("FAIL sweep_err c=%0d got=%b exp=%b", c, err, merr); end
`endif
      $display("sweep c=%0d sel=%0d d=%b vld=%b full=%b ack=%b v=%b o=%b", c, s, dd, vl, st, ak, dut_v(), dut_o());
    end
  endtask

  task automatic test_random();
    pulse_reset();
    for (int n = 0; n < 300; n++) begin
      drive(2'($urandom), W'($urandom), 1'($urandom), 4'($urandom));
      #1;
      checks++;
      if (rdy !== exp_rdy())
        begin errors++; $display("FAIL rand_rdy n=%0d got=%b exp=%b", n, rdy, exp_rdy()); end
      tick();
      checks++;
      if (dut_v() !== exp_v() || dut_o() !== exp_o())
        begin errors++; $display("FAIL rand_state n=%0d v=%b o=%b exp_v=%b exp_o=%b", n, dut_v(), dut_o(), exp_v(), exp_o()); end
`ifdef DEMUX_ERR_EN
      checks++;
      if (err !== merr) begin errors++; $display("FAIL rand_err n=%0d got=%b exp=%b", n, err, merr); end
`endif
      $display("random n=%0d sel=%0d v=%b o=%b", n, sel, dut_v(), dut_o());
    end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_back_to_back();
    test_full_drop();
    test_independent_acks();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
